load_store_unit: RTL and testbench

- Initiator side of the data-memory interface.
- Accepts one load/store request at a time from the core over a valid/ready handshake and converts its byte address to a 64-bit word index.
- Drives the memory's En/memRead/memWrite/address/write_data strobes and captures read_data.
- Sub-word loads are returned sign- or zero-extended. Sub-word stores are performed as read-modify-write, because the memory has no byte enables.

---
 rtl/load_store_unit_pkg.sv | 71 +++++++
 rtl/lsu_lane_align.sv | 18 +
 rtl/load_store_unit.sv | 115 +++++++++++
 tb/tb_load_store_unit.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// the lane extract/merge helpers used by the alignment datapath.
package load_store_unit_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } lsu_state_e;

  // Byte mask (in bit units) covering the low 2^size bytes.
  function automatic logic [63:0] size_mask(input logic [1:0] size);
    logic [63:0] m;
    case (size)
      SZ_B:    m = 64'h0000_0000_0000_00FF;
      SZ_H:    m = 64'h0000_0000_0000_FFFF;
      SZ_W:    m = 64'h0000_0000_FFFF_FFFF;
      default: m = 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
    return m;
  endfunction

  // An access is misaligned when the low offset bits inside its size are nonzero.
  function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = off[0];
      SZ_W:    r = |off[1:0];
      default: r = |off;
    endcase
    return r;
  endfunction

  // Pick the addressed lane out of a little-endian word and extend it.
  function automatic logic [63:0] lane_extract(input logic [63:0] data, input logic [2:0] off,
                                               input logic [1:0] size, input logic sgn);
    logic        [63:0] sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic        [63:0] r;
    sh = data >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (size)
      SZ_B:    r = sgn ? 64'(b) : 64'(sh[7:0]);
      SZ_H:    r = sgn ? 64'(h) : 64'(sh[15:0]);
      SZ_W:    r = sgn ? 64'(w) : 64'(sh[31:0]);
      default: r = sh;
    endcase
    return r;
  endfunction

  // Replace the addressed lane of the old word with the low bytes of new data.
  function automatic logic [63:0] lane_merge(input logic [63:0] old_data, input logic [63:0] new_data,
                                             input logic [2:0] off, input logic [1:0] size);
    logic [63:0] m;
    m = size_mask(size);
    return (old_data & ~(m << {off, 3'b000})) | ((new_data & m) << {off, 3'b000});
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane datapath: extends load lanes and builds the
// read-modify-write merge word for sub-word stores.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [63:0] old_data,
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [63:0] new_data,
  output logic [63:0] ext_data,
  output logic [63:0] merged
);

  assign ext_data = lane_extract(old_data, off, size, sgn);
  assign merged   = lane_merge(old_data, new_data, off, size);

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, sub-word stores as
// read-modify-write, strobes decoded only from registered state.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter int ADDR_W     = 64,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic [63:0]       mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state;
  logic              write_q;
  logic              sgn_q;
  logic [1:0]        size_q;
  logic [2:0]        off_q;
  logic [DATA_W-1:0] wbuf;
  logic [DATA_W-1:0] ext_data;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              bad;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign bad       = misaligned(req_addr[2:0], req_size) | (|req_addr[ADDR_W-1:DEPTH_LOG2+3]);

  assign mem_read       = (state == READ);
  assign mem_write      = (state == WRITE);
  assign mem_en         = mem_read | mem_write;
  assign mem_write_data = mem_write ? wbuf : '0;

  lsu_lane_align u_align (
    .old_data (mem_read_data),
    .off      (off_q),
    .size     (size_q),
    .sgn      (sgn_q),
    .new_data (wbuf),
    .ext_data (ext_data),
    .merged   (merged)
  );

  // Request FSM with registered response and address; wbuf holds store data then the merge word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
      mem_address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            write_q    <= req_write;
            sgn_q      <= req_signed;
            size_q     <= req_size;
            off_q      <= req_addr[2:0];
            wbuf       <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= bad;
            if (bad) begin
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              mem_address <= 64'(req_addr[DEPTH_LOG2+2:3]);
              state       <= (req_write && req_size == SZ_D) ? WRITE : READ;
            end
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          if (write_q) begin
            wbuf  <= merged;
            state <= WRITE;
          end else begin
            resp_rdata <= ext_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        WRITE: begin
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural word memory, scoreboard of
// expected responses, backpressure and reset-during-write scenarios.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [63:0] resp_rdata;
  logic        mem_en, mem_read, mem_write;
  logic [63:0] mem_address, mem_write_data, mem_read_data;

  logic [63:0] mem [64];
  logic [63:0] rd_q;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    logic [15:0] sig;
    logic [63:0] idx;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 Clk = ~Clk;

  load_store_unit dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Memory: writes commit at the sampling edge, read data appears the cycle after.
  always @(posedge Clk) begin
    if (mem_en && mem_write) mem[mem_address[5:0]] <= mem_write_data;
    if (mem_en && mem_read)  rd_q <= mem[mem_address[5:0]];
  end
  assign mem_read_data = rd_q;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] exp_rd, input logic exp_err);
    exp_t        e;
    exp_t        x;
    int          n;
    logic [15:0] sig;
    logic        saw_en;
    logic [63:0] idx_seen;
    e.rdata = (exp_err || wr) ? 64'd0 : exp_rd;
    e.err   = exp_err;
    e.idx   = addr >> 3;
    if (exp_err)      begin e.lat = 1; e.sig = 16'b0;      end
    else if (!wr)     begin e.lat = 3; e.sig = 16'b1000;   end
    else if (sz == 3) begin e.lat = 2; e.sig = 16'b01;     end
    else              begin e.lat = 4; e.sig = 16'b100001; end
    sb.push_back(e);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge Clk); n++; end
    if (!req_ready) chk({tag, "_accept"}, 64'd0, 64'd1);
    @(negedge Clk);
    req_valid = 1'b0;
    n = 1; sig = '0; saw_en = 1'b0; idx_seen = '0;
    while (!resp_valid && n < 10) begin
      sig = {sig[13:0], mem_read, mem_write};
      if (mem_en) begin saw_en = 1'b1; idx_seen = mem_address; end
      @(negedge Clk);
      n++;
    end
    x = sb.pop_front();
    chk({tag, "_lat"},   64'(n),        64'(x.lat));
    chk({tag, "_rdata"}, resp_rdata,    x.rdata);
    chk({tag, "_err"},   64'(resp_err), 64'(x.err));
    chk({tag, "_seq"},   64'(sig),      64'(x.sig));
    chk({tag, "_en"},    64'(saw_en),   64'(!x.err));
    if (!x.err) chk({tag, "_addr"}, idx_seen, x.idx);
    @(negedge Clk);
    chk({tag, "_idle"}, 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    exp_t e;
    int   n;
    Rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_resp", 64'({resp_valid, resp_err}), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_strobe", 64'({mem_en, mem_read, mem_write}), 64'd0);
    chk("rst_maddr", mem_address, 64'd0);
    chk("rst_wdata", mem_write_data, 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    Rst = 1'b0;
    @(negedge Clk);

    run_req("st_d",  1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788, 64'd0, 1'b0);
    run_req("ld_d",  1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 64'h1122334455667788, 1'b0);
    run_req("st_w1", 1'b1, 2'd3, 1'b0, 64'h08, 64'hF0, 64'd0, 1'b0);
    run_req("ld_bs", 1'b0, 2'd0, 1'b1, 64'h08, 64'd0, 64'hFFFFFFFFFFFFFFF0, 1'b0);
    run_req("ld_bu", 1'b0, 2'd0, 1'b0, 64'h08, 64'd0, 64'h00000000000000F0, 1'b0);
    run_req("st_w2", 1'b1, 2'd3, 1'b0, 64'h10, 64'hAAAAAAAAAAAAAAAA, 64'd0, 1'b0);
    run_req("st_h",  1'b1, 2'd1, 1'b0, 64'h14, 64'h1234, 64'd0, 1'b0);
    chk("rmw_word2", mem[2], 64'hAAAA1234AAAAAAAA);
    run_req("ld_hs", 1'b0, 2'd1, 1'b1, 64'h16, 64'd0, 64'hFFFFFFFFFFFFAAAA, 1'b0);
    run_req("ld_wu", 1'b0, 2'd2, 1'b0, 64'h14, 64'd0, 64'h00000000AAAA1234, 1'b0);
    run_req("st_b",  1'b1, 2'd0, 1'b0, 64'h1F, 64'hFF99, 64'd0, 1'b0);
    run_req("ld_d3", 1'b0, 2'd3, 1'b0, 64'h18, 64'd0, 64'h9922334455667788, 1'b0);
    run_req("err_mis", 1'b0, 2'd2, 1'b0, 64'h0A,  64'd0, 64'd0, 1'b1);
    run_req("err_rng", 1'b0, 2'd3, 1'b0, 64'h200, 64'd0, 64'd0, 1'b1);
    run_req("err_st",  1'b1, 2'd1, 1'b0, 64'h11,  64'hFFFF, 64'd0, 1'b1);
    chk("err_nowrite", mem[2], 64'hAAAA1234AAAAAAAA);

    // Backpressure: response must hold, and a second request must be ignored.
    e.rdata = 64'h9922334455667788; e.err = 1'b0; e.lat = 3; e.sig = '0; e.idx = 64'd3;
    sb.push_back(e);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd3; req_signed = 1'b0; req_addr = 64'h18;
    @(negedge Clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 10) begin @(negedge Clk); n++; end
    e = sb.pop_front();
    chk("bp_lat", 64'(n), 64'(e.lat));
    chk("bp_rdata", resp_rdata, e.rdata);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 64'h18; req_wdata = 64'd0;
      @(negedge Clk);
      chk("bp_valid", 64'(resp_valid), 64'd1);
      chk("bp_hold", resp_rdata, e.rdata);
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_noen", 64'(mem_en), 64'd0);
    end
    req_valid = 1'b0; resp_ready = 1'b1;
    @(negedge Clk);
    chk("bp_done", 64'({resp_valid, req_ready}), 64'(2'b01));
    @(negedge Clk);
    chk("bp_quiet", 64'({mem_en, resp_valid}), 64'd0);
    chk("bp_mem", mem[3], 64'h9922334455667788);

    // Reset landing on the WRITE cycle of a dword store.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd3; req_addr = 64'h20; req_wdata = 64'h5;
    @(negedge Clk);
    req_valid = 1'b0;
    chk("rw_write", 64'(mem_write), 64'd1);
    Rst = 1'b1;
    @(negedge Clk);
    chk("rw_idle", 64'({req_ready, resp_valid, mem_en}), 64'(3'b100));
    Rst = 1'b0;
    chk("rw_commit", mem[4], 64'h5);
    run_req("rw_ld", 1'b0, 2'd3, 1'b0, 64'h20, 64'd0, 64'h5, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
